// File: rtl/mmcm_drp_seq.sv
// MMCM/PLL DRP reconfiguration sequencer: holds the primitive in reset, read-modify-writes
// NUM_REGS table entries over DRP, then waits for LOCKED. Optional macro: LOCK_TIMEOUT_EN.
module mmcm_drp_seq #(
    parameter int NUM_REGS     = 23,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  tbl_idx,
    input  logic [6:0]  tbl_addr,
    input  logic [15:0] tbl_mask,
    input  logic [15:0] tbl_data,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    output logic        den,
    output logic        dwe,
    input  logic [15:0] do_i,
    input  logic        drdy,
    output logic        pll_rst,
    input  logic        pll_locked
);
    typedef enum logic [2:0] {
        IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, WAIT_LOCK, ERR
    } state_t;

    localparam logic [31:0] HOLD_INIT = 32'(RST_HOLD - 1);
    localparam logic [4:0]  LAST_IDX  = 5'(NUM_REGS - 1);
`ifdef LOCK_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'd31;
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
`endif

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] di_q, di_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [4:0]  idx_q, idx_d;
    logic        den_q, den_d, dwe_q, dwe_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d, prst_q, prst_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            cap_q   <= 16'd0;
            di_q    <= 16'd0;
            daddr_q <= 7'd0;
            idx_q   <= 5'd0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            prst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            di_q    <= di_d;
            daddr_q <= daddr_d;
            idx_q   <= idx_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            prst_q  <= prst_d;
        end
    end

    // Next-state decode; start from ERR restarts exactly like start from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = HOLD; else state_d = IDLE;
            HOLD:    if (cnt_q == 32'd0) state_d = RD; else state_d = HOLD;
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                if (drdy) state_d = WR;
`ifdef LOCK_TIMEOUT_EN
                else if (cnt_q == WDOG_LAST) state_d = ERR;
`endif
                else state_d = RD_WAIT;
            end
            WR:      state_d = WR_WAIT;
            WR_WAIT: begin
                if (drdy) state_d = (idx_q < LAST_IDX) ? RD : WAIT_LOCK;
`ifdef LOCK_TIMEOUT_EN
                else if (cnt_q == WDOG_LAST) state_d = ERR;
`endif
                else state_d = WR_WAIT;
            end
            WAIT_LOCK: begin
                if (pll_locked) state_d = IDLE;
`ifdef LOCK_TIMEOUT_EN
                else if (cnt_q == LOCK_LAST) state_d = ERR;
`endif
                else state_d = WAIT_LOCK;
            end
            ERR:     if (start) state_d = HOLD; else state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values, derived from the current state and the chosen transition
    always_comb begin
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        di_d    = di_q;
        daddr_d = daddr_q;
        idx_d   = idx_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        prst_d  = prst_q;
        case (state_q)
            IDLE, ERR: begin
                if (state_d == HOLD) begin
                    busy_d = 1'b1;
                    prst_d = 1'b1;
                    idx_d  = 5'd0;
                    cnt_d  = HOLD_INIT;
                end else begin
                    busy_d = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1; else cnt_d = 32'd0;
            end
            RD: begin
                den_d   = 1'b1;
                daddr_d = tbl_addr;
                cnt_d   = 32'd0;
            end
            RD_WAIT: begin
                if (drdy) cap_d = do_i; else cap_d = cap_q;
                cnt_d = cnt_q + 32'd1;
            end
            WR: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                daddr_d = tbl_addr;
                di_d    = (cap_q & tbl_mask) | (tbl_data & ~tbl_mask);
                cnt_d   = 32'd0;
            end
            WR_WAIT: begin
                if (state_d == RD) begin
                    idx_d = idx_q + 5'd1;
                end else if (state_d == WAIT_LOCK) begin
                    prst_d = 1'b0;
                    cnt_d  = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_LOCK: begin
                if (state_d == IDLE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
        // Entering ERR drops the primitive reset and busy, and flags once
        if (state_d == ERR && state_q != ERR) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            prst_d  = 1'b0;
        end else begin
            error_d = 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign tbl_idx = idx_q;
    assign daddr   = daddr_q;
    assign di      = di_q;
    assign den     = den_q;
    assign dwe     = dwe_q;
    assign pll_rst = prst_q;
endmodule

// File: tb/tb_mmcm_drp_seq.sv
// Self-checking bench for mmcm_drp_seq: table-driven reconfiguration vectors plus
// hand-written reset, restart and (with LOCK_TIMEOUT_EN) timeout sequences.
module tb_mmcm_drp_seq;
    localparam int NREG  = 2;
    localparam int RHOLD = 4;

    logic        clk, rst, start, busy, done, error, den, dwe, drdy, pll_rst, pll_locked;
    logic [4:0]  tbl_idx;
    logic [6:0]  tbl_addr, daddr;
    logic [15:0] tbl_mask, tbl_data, di, do_i;

    logic [6:0]  ta0, ta1;
    logic [15:0] tm0, tm1, td0, td1, rdval;
    logic        model_en, d1_r, outstanding;
    int          den_cnt, wr_cnt, done_cnt, viol;
    logic [6:0]  den_addr [256];
    logic [6:0]  wr_addr  [256];
    logic [15:0] wr_data  [256];
    int          checks, errors;

    typedef struct {
        logic [6:0]  a0;
        logic [15:0] m0, d0;
        logic [6:0]  a1;
        logic [15:0] m1, d1, rd, w0, w1;
        bit          restart;
    } vec_t;
    vec_t vecs [4];

    mmcm_drp_seq #(.NUM_REGS(NREG), .LOCK_TIMEOUT(100), .RST_HOLD(RHOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
        .daddr(daddr), .di(di), .den(den), .dwe(dwe), .do_i(do_i), .drdy(drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tbl_addr = (tbl_idx == 5'd0) ? ta0 : ta1;
    assign tbl_mask = (tbl_idx == 5'd0) ? tm0 : tm1;
    assign tbl_data = (tbl_idx == 5'd0) ? td0 : td1;
    assign do_i     = rdval;

    initial begin
        d1_r = 1'b0; drdy = 1'b0; outstanding = 1'b0;
        den_cnt = 0; wr_cnt = 0; done_cnt = 0; viol = 0;
    end

    // DRP slave model (drdy two cycles after den) and bus monitor
    always @(posedge clk) begin
        d1_r <= den & model_en;
        drdy <= d1_r;
        if (rst) outstanding <= 1'b0;
        else if (den) outstanding <= 1'b1;
        else if (drdy) outstanding <= 1'b0;
        if (den) begin
            viol <= viol + int'(outstanding) + int'(!pll_rst);
            den_addr[den_cnt[7:0]] <= daddr;
            den_cnt <= den_cnt + 1;
            if (dwe) begin
                wr_addr[wr_cnt[7:0]] <= daddr;
                wr_data[wr_cnt[7:0]] <= di;
                wr_cnt <= wr_cnt + 1;
            end
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tbl(input vec_t v);
        ta0 = v.a0; tm0 = v.m0; td0 = v.d0;
        ta1 = v.a1; tm1 = v.m1; td1 = v.d1;
        rdval = v.rd;
    endtask

    task automatic run_seq(input vec_t v, input bit lock);
        int db, wb, dnb, n;
        bit injected;
        load_tbl(v);
        db = den_cnt; wb = wr_cnt; dnb = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pll_rst", 32'(pll_rst), 32'd1);
        n = 0;
        while (!den && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_to_first_den", n, RHOLD + 1);
        injected = 1'b0;
        n = 0;
        while (pll_rst && n < 300) begin
            if (v.restart && !injected && den && !dwe) begin
                start = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("pll_rst_released", 32'(pll_rst), 32'd0);
        chk("busy_wait_lock", 32'(busy), 32'd1);
        chk("den_pulses", den_cnt - db, 32'(2 * NREG));
        chk("rd0_addr", 32'(den_addr[db[7:0]]), 32'(v.a0));
        chk("wr0_addr", 32'(den_addr[8'(db + 1)]), 32'(v.a0));
        chk("rd1_addr", 32'(den_addr[8'(db + 2)]), 32'(v.a1));
        chk("wr1_addr", 32'(wr_addr[8'(wb + 1)]), 32'(v.a1));
        chk("wr0_data", 32'(wr_data[wb[7:0]]), 32'(v.w0));
        chk("wr1_data", 32'(wr_data[8'(wb + 1)]), 32'(v.w1));
        if (lock) begin
            repeat (2) @(negedge clk);
            chk("no_done_before_lock", 32'(done), 32'd0);
            pll_locked = 1'b1;
            @(negedge clk);
            chk("done_after_lock", 32'(done), 32'd1);
            chk("busy_after_lock", 32'(busy), 32'd0);
            pll_locked = 1'b0;
            @(negedge clk);
            chk("done_single", 32'(done), 32'd0);
            chk("done_count", done_cnt - dnb, 32'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_den_dwe"}, {30'd0, den, dwe}, 32'd0);
        chk({tag, "_daddr"}, 32'(daddr), 32'd0);
        chk({tag, "_di"}, 32'(di), 32'd0);
        chk({tag, "_tbl_idx"}, 32'(tbl_idx), 32'd0);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd0);
    endtask

    initial begin
        int n, db, bad;
        checks = 0; errors = 0;
        vecs[0] = '{7'h08, 16'h1000, 16'h0041, 7'h09, 16'hFC00, 16'h0000, 16'hFFFF, 16'h1041, 16'hFC00, 1'b0};
        vecs[1] = '{7'h08, 16'h1000, 16'h0041, 7'h09, 16'hFC00, 16'h0000, 16'h0000, 16'h0041, 16'h0000, 1'b0};
        vecs[2] = '{7'h10, 16'h00FF, 16'hAB00, 7'h7F, 16'hFFFF, 16'h1234, 16'h5A5A, 16'hAB5A, 16'h5A5A, 1'b1};
        vecs[3] = '{7'h01, 16'h0000, 16'hBEEF, 7'h00, 16'hF0F0, 16'h0F0F, 16'h1234, 16'hBEEF, 16'h1F3F, 1'b0};
        rst = 1'b1; start = 1'b0; pll_locked = 1'b0; model_en = 1'b1;
        load_tbl(vecs[0]);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_seq(vecs[i], 1'b1);
            repeat (2) @(negedge clk);
        end

        // Reset during the final WR_WAIT; the late drdy must be ignored
        load_tbl(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(den && dwe && tbl_idx == 5'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wr_wait_1", {31'd0, den & dwe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        db = den_cnt;
        repeat (5) @(negedge clk);
        chk("late_drdy_busy", 32'(busy), 32'd0);
        chk("late_drdy_no_den", den_cnt - db, 32'd0);
        chk("late_drdy_idx", 32'(tbl_idx), 32'd0);
        run_seq(vecs[0], 1'b1);
        repeat (2) @(negedge clk);

`ifdef LOCK_TIMEOUT_EN
        run_seq(vecs[0], 1'b0);
        n = 0;
        while (!error && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("lock_timeout_cycles", n, 32'd100);
        chk("lock_timeout_busy", 32'(busy), 32'd0);
        chk("lock_timeout_pll_rst", 32'(pll_rst), 32'd0);
        @(negedge clk);
        chk("lock_timeout_error_pulse", 32'(error), 32'd0);
        run_seq(vecs[1], 1'b1);
        repeat (2) @(negedge clk);

        model_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!den && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drdy_watchdog_cycles", n, 32'd32);
        chk("drdy_watchdog_pll_rst", 32'(pll_rst), 32'd0);
        chk("drdy_watchdog_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
`else
        run_seq(vecs[0], 1'b0);
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || error !== 1'b0) bad++;
        end
        chk("no_timeout_wait", bad, 32'd0);
        pll_locked = 1'b1;
        @(negedge clk);
        chk("late_lock_done", 32'(done), 32'd1);
        pll_locked = 1'b0;
        @(negedge clk);
`endif
        chk("drp_protocol", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
